// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, credit-limited in-order requests to instruction
// memory, a small response FIFO toward decode, and branch redirect with in-flight dropping.
module fetch_unit #(
    parameter int                  num_bits = 32,
    parameter logic [num_bits-1:0] reset_pc = '0,
    parameter int                  depth    = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [num_bits-1:0] imem_addr,
    input  logic                imem_resp_valid,
    input  logic [num_bits-1:0] imem_resp_data,
    input  logic                branch_taken,
    input  logic [num_bits-1:0] branch_target,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [num_bits-1:0] instr,
    output logic [num_bits-1:0] instr_pc
);
    localparam int cw = $clog2(depth) + 1;
    localparam int pw = $clog2(depth);

    logic [num_bits-1:0] pc_q, pc_d, resp_pc_q, resp_pc_d;
    logic [cw-1:0]       count_q, count_d, outstanding_q, outstanding_d, drop_q, drop_d;
    logic [pw-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [num_bits-1:0] data_q [depth];
    logic [num_bits-1:0] data_d [depth];
    logic [num_bits-1:0] ipc_q  [depth];
    logic [num_bits-1:0] ipc_d  [depth];

    logic [cw:0]   in_use;
    logic          fire, pop, push, dropping;
    logic [cw-1:0] outstanding_eff, drop_eff;

    always_comb begin
        in_use          = {1'b0, outstanding_q} + {1'b0, count_q};
        imem_req_valid  = reset_n && (in_use < (cw+1)'(depth)) && !branch_taken;
        imem_addr       = pc_q;
        instr_valid     = reset_n && (count_q != '0) && !branch_taken;
        instr           = data_q[rd_ptr_q];
        instr_pc        = ipc_q[rd_ptr_q];

        fire            = imem_req_valid && imem_req_ready;
        pop             = instr_valid && instr_ready;
        dropping        = imem_resp_valid && (drop_q != '0);
        push            = imem_resp_valid && !dropping && !branch_taken;
        outstanding_eff = outstanding_q - cw'(imem_resp_valid);
        drop_eff        = drop_q - cw'(dropping);

        pc_d          = pc_q;
        resp_pc_d     = resp_pc_q;
        count_d       = count_q;
        outstanding_d = outstanding_eff;
        drop_d        = drop_eff;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        data_d        = data_q;
        ipc_d         = ipc_q;

        if (branch_taken) begin
            pc_d      = branch_target;
            resp_pc_d = branch_target;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            // Words already marked for dropping are part of outstanding, so every word
            // still in flight is dropped exactly once, however many redirects stack up.
            drop_d    = outstanding_eff;
        end else begin
            if (fire) begin
                pc_d          = pc_q + num_bits'(4);
                outstanding_d = outstanding_eff + cw'(1);
            end
            if (push) begin
                data_d[wr_ptr_q] = imem_resp_data;
                ipc_d[wr_ptr_q]  = resp_pc_q;
                wr_ptr_d         = wr_ptr_q + pw'(1);
                resp_pc_d        = resp_pc_q + num_bits'(4);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + pw'(1);
            count_d = count_q + cw'(push) - cw'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc_q          <= reset_pc;
            resp_pc_q     <= reset_pc;
            count_q       <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            pc_q          <= pc_d;
            resp_pc_q     <= resp_pc_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // FIFO storage needs no reset; entries are only read once count covers them.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        ipc_q  <= ipc_d;
    end

    // A response with nothing outstanding means the memory model is broken.
    assert property (@(posedge clk) disable iff (!reset_n) imem_resp_valid |-> outstanding_q != '0);

endmodule
